// File: rtl/hazard_pkg.sv
// hazard_pkg: types, constants and helpers shared by hazard_unit and its shadow pipeline.
package hazard_pkg;

  localparam int REG_AW = 5;

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Writeback source of an instruction.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Per-stage metadata carried down the shadow pipeline.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              load;
  } stage_meta_t;

  // True when the stage writes a non-x0 register that matches rs.
  function automatic logic writes_reg(input stage_meta_t m, input logic [REG_AW-1:0] rs);
    return m.reg_write && (m.rd != '0) && (m.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: E/M/W metadata register chain mirroring the datapath pipeline.
// A flush turns the E entry into a bubble; M and W always advance.
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  stage_meta_t       meta_d_i,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  output stage_meta_t       meta_e_o,
  output logic [REG_AW-1:0] rs1_e_o,
  output logic [REG_AW-1:0] rs2_e_o,
  output stage_meta_t       meta_m_o,
  output stage_meta_t       meta_w_o
);

  stage_meta_t       meta_e_q, meta_m_q, meta_w_q;
  stage_meta_t       meta_e_d;
  logic [REG_AW-1:0] rs1_e_q, rs2_e_q, rs1_e_d, rs2_e_d;

  // E-stage next value: Decode fields, or an all-zero bubble on flush.
  always_comb begin
    meta_e_d = meta_d_i;
    rs1_e_d  = rs1_d_i;
    rs2_e_d  = rs2_d_i;
    if (flush_i) begin
      meta_e_d = '0;
      rs1_e_d  = '0;
      rs2_e_d  = '0;
    end
  end

  // Shadow registers advance every cycle; reset empties the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_e_q <= '0;
      rs1_e_q  <= '0;
      rs2_e_q  <= '0;
      meta_m_q <= '0;
      meta_w_q <= '0;
    end else begin
      meta_e_q <= meta_e_d;
      rs1_e_q  <= rs1_e_d;
      rs2_e_q  <= rs2_e_d;
      meta_m_q <= meta_e_q;
      meta_w_q <= meta_m_q;
    end
  end

  assign meta_e_o = meta_e_q;
  assign rs1_e_o  = rs1_e_q;
  assign rs2_e_o  = rs2_e_q;
  assign meta_m_o = meta_m_q;
  assign meta_w_o = meta_w_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, load-use / RAW stalls and branch flushes for a
// 5-stage RISC-V pipeline, with a saturating stall-cycle counter.
// Build option: define HAZARD_FORWARD_EN to enable operand forwarding; without it the
// forward selects stay 00 and any E/M producer of a Decode source stalls Decode.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic [1:0]        result_src_d,
  input  logic              pc_src_e,
  output logic [1:0]        forward_srcA_e,
  output logic [1:0]        forward_srcB_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_count
);

  // REG_AW must equal hazard_pkg::REG_AW; the shadow metadata struct is sized by the package.
  import hazard_pkg::*;

  stage_meta_t       meta_d, meta_e, meta_m, meta_w;
  logic [REG_AW-1:0] rs1_e, rs2_e;
  fwd_sel_t          fwd_a, fwd_b;
  logic              hazard;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              unused_meta;

  assign meta_d = '{rd: rd_d, reg_write: reg_write_d, load: (result_src_d == RES_MEM)};

  hazard_shadow_pipe u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush_e),
    .meta_d_i (meta_d),
    .rs1_d_i  (rs1_d),
    .rs2_d_i  (rs2_d),
    .meta_e_o (meta_e),
    .rs1_e_o  (rs1_e),
    .rs2_e_o  (rs2_e),
    .meta_m_o (meta_m),
    .meta_w_o (meta_w)
  );

  // Not every shadow field is consumed in every build configuration.
  assign unused_meta = ^{rs1_e, rs2_e, meta_e, meta_m, meta_w};

  // Forward selection (M beats W) and the Decode stall condition for this build.
  always_comb begin
    fwd_a  = FWD_RF;
    fwd_b  = FWD_RF;
    hazard = 1'b0;
`ifdef HAZARD_FORWARD_EN
    if (writes_reg(meta_m, rs1_e))      fwd_a = FWD_M;
    else if (writes_reg(meta_w, rs1_e)) fwd_a = FWD_W;
    if (writes_reg(meta_m, rs2_e))      fwd_b = FWD_M;
    else if (writes_reg(meta_w, rs2_e)) fwd_b = FWD_W;
    // Only a load in E cannot be forwarded in time.
    hazard = meta_e.load && (meta_e.rd != '0) &&
             ((meta_e.rd == rs1_d) || (meta_e.rd == rs2_d));
`else
    // No bypass: hold Decode until every producer has reached W.
    hazard = writes_reg(meta_e, rs1_d) || writes_reg(meta_e, rs2_d) ||
             writes_reg(meta_m, rs1_d) || writes_reg(meta_m, rs2_d);
`endif
  end

  // Stall/flush arbitration: a taken branch overrides the stall; reset forces all low.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst_n) begin
      stall_f = hazard && !pc_src_e;
      stall_d = hazard && !pc_src_e;
      flush_d = pc_src_e;
      flush_e = hazard || pc_src_e;
    end
  end

  assign forward_srcA_e = fwd_a;
  assign forward_srcB_e = fwd_b;

  // Stall-cycle counter next value, saturating at all-ones.
  always_comb begin
    count_d = count_q;
    if (stall_d && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against an instruction-level
// pipeline model. A second instance with a 3-bit counter exercises saturation.
module tb_hazard_unit;

  localparam int SAT_W = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       reg_write_d = 1'b0;
  logic [1:0] result_src_d = '0;
  logic       pc_src_e = 1'b0;

  logic [1:0]  fa, fb;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [31:0] cnt;
  logic [1:0]  fa_s, fb_s;
  logic        stall_f_s, stall_d_s, flush_d_s, flush_e_s;
  logic [SAT_W-1:0] cnt_s;

  int tests = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .pc_src_e(pc_src_e),
    .forward_srcA_e(fa), .forward_srcB_e(fb), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_count(cnt)
  );

  hazard_unit #(.REG_AW(5), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .pc_src_e(pc_src_e),
    .forward_srcA_e(fa_s), .forward_srcB_e(fb_s), .stall_f(stall_f_s), .stall_d(stall_d_s),
    .flush_d(flush_d_s), .flush_e(flush_e_s), .stall_count(cnt_s)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         wr;
    logic [1:0] src;
  } ins_t;

  // Instructions that entered Execute, oldest first: [0]=W, [1]=M, [2]=E.
  ins_t   pipe_q[$];
  longint m_cnt;
  bit     m_stalled;

  // Values seen at the most recent step, for hand-computed expectations.
  logic [1:0]  got_fa, got_fb;
  logic        got_sf, got_sd, got_fd, got_fe;
  logic [31:0] got_cnt;

  function automatic ins_t mk(input int rd, input int rs1, input int rs2, input bit wr, input int src);
    ins_t i;
    i.rd  = rd[4:0];
    i.rs1 = rs1[4:0];
    i.rs2 = rs2[4:0];
    i.wr  = wr;
    i.src = src[1:0];
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(0, 0, 0, 1'b0, 0);
  endfunction

  function automatic void model_reset();
    pipe_q.delete();
    for (int k = 0; k < 3; k++) pipe_q.push_back(bubble());
    m_cnt = 0;
    m_stalled = 1'b0;
  endfunction

  function automatic bit produces(input ins_t p, input logic [4:0] r);
    return p.wr && (p.rd != 5'd0) && (p.rd == r);
  endfunction

  function automatic int exp_fwd(input logic [4:0] rs);
    int sel;
    sel = 0;
`ifdef HAZARD_FORWARD_EN
    if (produces(pipe_q[1], rs))      sel = 2;
    else if (produces(pipe_q[0], rs)) sel = 1;
`else
    if (rs == 5'd31) sel = 0;
`endif
    return sel;
  endfunction

  function automatic bit exp_hazard(input ins_t d);
    bit h;
`ifdef HAZARD_FORWARD_EN
    h = (pipe_q[2].src == 2'b01) && (pipe_q[2].rd != 5'd0) &&
        ((pipe_q[2].rd == d.rs1) || (pipe_q[2].rd == d.rs2));
`else
    h = produces(pipe_q[2], d.rs1) || produces(pipe_q[2], d.rs2) ||
        produces(pipe_q[1], d.rs1) || produces(pipe_q[1], d.rs2);
`endif
    return h;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input ins_t d, input bit br);
    rs1_d        = d.rs1;
    rs2_d        = d.rs2;
    rd_d         = d.rd;
    reg_write_d  = d.wr;
    result_src_d = d.src;
    pc_src_e     = br;
  endtask

  // One cycle: drive Decode at negedge, compare every output, then advance the model at posedge.
  task automatic step(input ins_t d, input bit br);
    bit h, e_stall, e_fe;
    longint sat_exp;
    @(negedge clk);
    drive(d, br);
    #1;
    h       = exp_hazard(d);
    e_stall = h && !br;
    e_fe    = h || br;
    sat_exp = (m_cnt > 7) ? 7 : m_cnt;
    chk("fwd_a",   {30'd0, fa}, exp_fwd(pipe_q[2].rs1));
    chk("fwd_b",   {30'd0, fb}, exp_fwd(pipe_q[2].rs2));
    chk("stall_f", {31'd0, stall_f}, {31'd0, e_stall});
    chk("stall_d", {31'd0, stall_d}, {31'd0, e_stall});
    chk("flush_d", {31'd0, flush_d}, {31'd0, br});
    chk("flush_e", {31'd0, flush_e}, {31'd0, e_fe});
    chk("count",   cnt, m_cnt[31:0]);
    chk("count_sat", {29'd0, cnt_s}, sat_exp[31:0]);
    got_fa = fa; got_fb = fb; got_sf = stall_f; got_sd = stall_d;
    got_fd = flush_d; got_fe = flush_e; got_cnt = cnt;
    @(posedge clk);
    void'(pipe_q.pop_front());
    pipe_q.push_back(e_fe ? bubble() : d);
    if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    m_stalled = e_stall;
  endtask

  task automatic drain();
    repeat (3) step(bubble(), 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fa"}, {30'd0, fa}, 0);
    chk({tag, "_fb"}, {30'd0, fb}, 0);
    chk({tag, "_stall_f"}, {31'd0, stall_f}, 0);
    chk({tag, "_stall_d"}, {31'd0, stall_d}, 0);
    chk({tag, "_flush_d"}, {31'd0, flush_d}, 0);
    chk({tag, "_flush_e"}, {31'd0, flush_e}, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_cnt_sat"}, {29'd0, cnt_s}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ins_t d;
    logic [31:0] c0;

    model_reset();
    pc_src_e = 1'b1;
    #2;
    chk_all_zero("reset_hold");
    pc_src_e = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef HAZARD_FORWARD_EN
    // add x5 ; sub x6,x5,x1 -> M forward on operand A, no stall
    drain();
    step(mk(5, 1, 2, 1, 0), 1'b0);
    step(mk(6, 5, 1, 1, 0), 1'b0);
    chk("b2b_no_stall", {31'd0, got_sd}, 0);
    step(bubble(), 1'b0);
    chk("b2b_fwd_a", {30'd0, got_fa}, 2);
    chk("b2b_fwd_b", {30'd0, got_fb}, 0);

    // add x5 ; nop ; or x7,x2,x5 -> W forward on operand B
    drain();
    step(mk(5, 1, 2, 1, 0), 1'b0);
    step(bubble(), 1'b0);
    step(mk(7, 2, 5, 1, 0), 1'b0);
    step(bubble(), 1'b0);
    chk("dist2_fwd_b", {30'd0, got_fb}, 1);
    chk("dist2_fwd_a", {30'd0, got_fa}, 0);

    // two writers of x5 back to back -> M wins over W
    drain();
    step(mk(5, 1, 2, 1, 0), 1'b0);
    step(mk(5, 3, 4, 1, 0), 1'b0);
    step(mk(8, 5, 5, 1, 0), 1'b0);
    step(bubble(), 1'b0);
    chk("prio_fwd_a", {30'd0, got_fa}, 2);
    chk("prio_fwd_b", {30'd0, got_fb}, 2);

    // lw x5 ; add x6,x5,x5 -> one bubble, then W forward on both operands
    drain();
    step(mk(5, 1, 0, 1, 1), 1'b0);
    c0 = got_cnt;
    step(mk(6, 5, 5, 1, 0), 1'b0);
    chk("lu_stall_f", {31'd0, got_sf}, 1);
    chk("lu_stall_d", {31'd0, got_sd}, 1);
    chk("lu_flush_e", {31'd0, got_fe}, 1);
    chk("lu_flush_d", {31'd0, got_fd}, 0);
    step(mk(6, 5, 5, 1, 0), 1'b0);
    chk("lu_released", {31'd0, got_sd}, 0);
    chk("lu_cnt_delta", got_cnt - c0, 1);
    step(bubble(), 1'b0);
    chk("lu_fwd_a", {30'd0, got_fa}, 1);
    chk("lu_fwd_b", {30'd0, got_fb}, 1);
`else
    // add x5 ; sub x6,x5,x1 without forwarding -> two stall cycles, selects stay 00
    drain();
    step(mk(5, 1, 2, 1, 0), 1'b0);
    c0 = got_cnt;
    step(mk(6, 5, 1, 1, 0), 1'b0);
    chk("raw_stall_f1", {31'd0, got_sf}, 1);
    chk("raw_stall_d1", {31'd0, got_sd}, 1);
    chk("raw_flush_e1", {31'd0, got_fe}, 1);
    chk("raw_flush_d1", {31'd0, got_fd}, 0);
    step(mk(6, 5, 1, 1, 0), 1'b0);
    chk("raw_stall_d2", {31'd0, got_sd}, 1);
    step(mk(6, 5, 1, 1, 0), 1'b0);
    chk("raw_released", {31'd0, got_sd}, 0);
    chk("raw_cnt_delta", got_cnt - c0, 2);
    step(bubble(), 1'b0);
    chk("raw_fwd_a", {30'd0, got_fa}, 0);
    chk("raw_fwd_b", {30'd0, got_fb}, 0);
`endif

    // hazard and taken branch together: branch wins, no stall, counter frozen
    drain();
    step(mk(5, 1, 0, 1, 1), 1'b0);
    c0 = got_cnt;
    step(mk(6, 5, 5, 1, 0), 1'b1);
    chk("br_stall_f", {31'd0, got_sf}, 0);
    chk("br_stall_d", {31'd0, got_sd}, 0);
    chk("br_flush_d", {31'd0, got_fd}, 1);
    chk("br_flush_e", {31'd0, got_fe}, 1);
    step(bubble(), 1'b0);
    chk("br_cnt_same", got_cnt, c0);

    // x0 is never a hazard source: addi x0 ; add x1,x0,x0 ; lw x0 ; add x3,x0,x0
    drain();
    step(mk(0, 1, 0, 1, 0), 1'b0);
    step(mk(1, 0, 0, 1, 0), 1'b0);
    chk("x0_no_stall", {31'd0, got_sd}, 0);
    step(bubble(), 1'b0);
    chk("x0_fwd_a", {30'd0, got_fa}, 0);
    chk("x0_fwd_b", {30'd0, got_fb}, 0);
    step(mk(0, 2, 0, 1, 1), 1'b0);
    step(mk(3, 0, 0, 1, 0), 1'b0);
    chk("x0_load_no_stall", {31'd0, got_sd}, 0);

    // asynchronous reset in the middle of a stall cycle
    drain();
    step(mk(5, 1, 0, 1, 1), 1'b0);
    @(negedge clk);
    drive(mk(6, 5, 5, 1, 0), 1'b0);
    #1;
    chk("pre_rst_stall", {31'd0, stall_d}, 1);
    #2;
    rst_n = 1'b0;
    pc_src_e = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    pc_src_e = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(mk(7, 5, 6, 1, 0), 1'b0);
    chk("post_rst_no_stall", {31'd0, got_sd}, 0);
    step(bubble(), 1'b0);
    chk("post_rst_fwd_a", {30'd0, got_fa}, 0);
    chk("post_rst_fwd_b", {30'd0, got_fb}, 0);

    // random traffic; a stalled Decode instruction is held until released
    d = bubble();
    for (int n = 0; n < 600; n++) begin
      if (!m_stalled)
        d = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
      step(d, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard controller for the 5-stage RISC-V pipeline. It drives the producer side of the operand-forwarding interface: it generates the 2-bit forward selects consumed by the Execute-stage source muxes, plus the stall and flush controls.
- It keeps its own shadow pipeline of destination-register and writeback metadata for the E, M and W stages, so it needs only Decode-stage fields and the branch-taken flag as inputs.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rs1_d  input  REG_AW  Decode source register 1.
- rs2_d  input  REG_AW  Decode source register 2.
- rd_d  input  REG_AW  Decode destination register.
- reg_write_d  input  1  Decode instruction writes the register file.
- result_src_d  input  2  writeback source of the Decode instruction: 00 ALU, 01 memory (load), 10 PC+4.
- pc_src_e  input  1  branch/jump taken, resolved in Execute.
- forward_srcA_e  output  2  Execute operand-A select: 00 register file, 01 W result, 10 M ALU result.
- forward_srcB_e  output  2  Execute operand-B select, same encoding as operand A.
- stall_f  output  1  hold the PC.
- stall_d  output  1  hold the F/D register.
- flush_d  output  1  clear the F/D register.
- flush_e  output  1  clear the D/E register.
- stall_count  output  CNT_W  number of cycles in which stall_d was asserted.

Behaviour:
- Shadow state
  - E stage: rd_e, rs1_e, rs2_e, reg_write_e, load_e.
  - M stage: rd_m, reg_write_m.
  - W stage: rd_w, reg_write_w.
  - Every rising clk edge: M←E, W←M.
  - E←D metadata when flush_e=0.
  - When flush_e=1, E becomes a bubble: all fields zero, reg_write_e=0.
- Reset (rst_n low, asynchronous): all shadow registers and stall_count clear to 0. While reset is held, all outputs read 0: forward selects 00, stall_f=stall_d=flush_d=flush_e=0. Reset asserted mid-operation discards in-flight hazards immediately.
- Forwarding (combinational from shadow state)
  - forward_srcA_e = 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
  - Otherwise 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
  - Otherwise 00.
  - forward_srcB_e uses the same rule with rs2_e.
  - M takes priority over W when both match. x0 is never forwarded.
- Load-use stall: lw_stall = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- Stall and flush outputs
  - stall_f = stall_d = lw_stall && !pc_src_e.
  - flush_e = lw_stall || pc_src_e.
  - flush_d = pc_src_e.
- Simultaneous load-use stall and taken branch: the branch wins. No stall; both D and E are flushed, because the stalled instruction is wrong-path.
- Latency: a load-use hazard costs exactly 1 bubble. After the bubble the load is in M and is older than the consumer, so the consumer picks up the loaded value through the W forward (01) on the following cycle.
- Register file writes in the first half-cycle. W→D hazards therefore need no handling.
- stall_count
  - Increments by 1 on each clk edge where stall_d=1.
  - Saturates at all-ones; no wrap-around.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding behaves as specified above.
- Undefined:
  - forward_srcA_e and forward_srcB_e are tied to 00.
  - lw_stall is replaced by raw_stall, asserted when any E or M shadow entry has reg_write set, rd!=0 and rd equal to rs1_d or rs2_d. The instruction stays in D until its producer reaches W.
  - Branch priority and the stall_count rules are unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - result_src_t enum (RES_ALU, RES_MEM, RES_PC4);
  - REG_AW constant;
  - stage_meta_t struct (rd, reg_write, load).
- One sub-module is natural: hazard_shadow_pipe, the E/M/W metadata register chain with asynchronous reset and the flush_e bubble insertion. Comparators and output logic stay in hazard_unit.

Test Plan:
- Back-to-back ALU ops: add x5 then sub x6,x5,x1 → on the sub's E cycle forward_srcA_e=10, no stall.
- ALU result consumed two instructions later: add x5 followed two instructions later by or x7,x2,x5 → forward_srcB_e=01.
- Load-use: lw x5 then add x6,x5,x5 → exactly one cycle with stall_f=stall_d=flush_e=1, stall_count 0→1; next cycle both forward selects=01.
- Load-use stall and branch taken in the same cycle: lw_stall condition with pc_src_e=1 → stall_f=stall_d=0, flush_d=flush_e=1, stall_count unchanged.
- x0 destination: addi x0 then add x1,x0,x0 → both forward selects=00 and no stall. Repeat with HAZARD_FORWARD_EN undefined: add x5, add x6,x5 → two stall cycles, forward selects 00 throughout.
- Reset: assert rst_n low mid-stall (asynchronously, between edges) → all outputs 0 immediately and stall_count=0; after release, first instruction sees forward selects 00.
